// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter/sequencer for the shared 4-bit ALU
// Optional ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties (no round-robin pointer).
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [1:0] op0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [1:0] op1,
  output logic       ack0,
  output logic       ack1,
  output logic [3:0] result,
  output logic [3:0] flags,
  output logic       gnt_id,
  output logic       busy,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_ctrl,
  input  logic [3:0] alu_result,
  input  logic       alu_v,
  input  logic       alu_c,
  input  logic       alu_n,
  input  logic       alu_z
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;
  logic   win_any;
  logic   win_id;

  assign win_any = req0 | req1;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 takes the ALU whenever it asks.
  always_comb begin
    win_id = ~req0;
  end
`else
  logic ptr;

  always_comb begin
    win_id = (req0 && req1) ? ptr : req1;
  end

  // The pointer moves away from whoever was just served, even without contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (state == DONE) begin
      ptr <= ~gnt_id;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_any) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_id   <= 1'b0;
      alu_a    <= 4'd0;
      alu_b    <= 4'd0;
      alu_ctrl <= 2'd0;
      result   <= 4'd0;
      flags    <= 4'd0;
    end else begin
      if (state == IDLE && win_any) begin
        gnt_id   <= win_id;
        alu_a    <= win_id ? a1  : a0;
        alu_b    <= win_id ? b1  : b0;
        alu_ctrl <= win_id ? op1 : op0;
      end
      if (state == EXEC) begin
        result <= alu_result;
        flags  <= {alu_v, alu_c, alu_n, alu_z};
      end
    end
  end

  assign busy = (state != IDLE);
  assign ack0 = (state == DONE) && !gnt_id;
  assign ack1 = (state == DONE) &&  gnt_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a transaction-level model
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic       ack0, ack1, gnt_id, busy;
  logic [3:0] result, flags, alu_a, alu_b, alu_result;
  logic [1:0] alu_ctrl;
  logic       alu_v, alu_c, alu_n, alu_z;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .ack0(ack0), .ack1(ack1), .result(result), .flags(flags),
    .gnt_id(gnt_id), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z)
  );

  // ALU arithmetic from integer rules; returns {V,C,N,Z,result}.
  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int ua, ub, sa, sb, u, s;
    logic [3:0] r;
    logic v, c;
    ua = a; ub = b;
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    v = 1'b0; c = 1'b0;
    case (op)
      2'd0: begin u = ua + ub; r = u[3:0]; c = (u > 15); s = sa + sb; v = (s > 7) || (s < -8); end
      2'd1: begin u = ua + 16 - ub; r = u[3:0]; c = (ua >= ub); s = sa - sb; v = (s > 7) || (s < -8); end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {v, c, r[3], (r == 4'd0), r};
  endfunction

  assign {alu_v, alu_c, alu_n, alu_z, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);

  // Transaction model: cycles_left counts down 2 (executing), 1 (acknowledging), 0 (free).
  int         cycles_left;
  logic       m_gnt, m_prefer;
  logic [3:0] m_a, m_b, m_res, m_flg;
  logic [1:0] m_op;

  task automatic model_edge();
    logic w;
    if (rst) begin
      cycles_left = 0; m_gnt = 0; m_prefer = 0;
      m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flg = 0;
    end else if (cycles_left == 0) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? m_prefer : req1;
        m_gnt = w;
        m_a = w ? a1 : a0; m_b = w ? b1 : b0; m_op = w ? op1 : op0;
        cycles_left = 2;
      end
    end else if (cycles_left == 2) begin
      {m_flg, m_res} = alu_ref(m_a, m_b, m_op);
      cycles_left = 1;
    end else begin
`ifndef ALU_ARB_FIXED_PRIO_EN
      m_prefer = !m_gnt;
`endif
      cycles_left = 0;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("busy", busy, cycles_left != 0);
    check("ack0", ack0, (cycles_left == 1) && !m_gnt);
    check("ack1", ack1, (cycles_left == 1) && m_gnt);
    check("gnt_id", gnt_id, m_gnt);
    check("result", result, m_res);
    check("flags", flags, m_flg);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_ctrl", alu_ctrl, m_op);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  int ack_seq[$];
  int busy_low;

  initial begin
    rst = 1; req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    step();
    check("rst_state", {ack0, ack1, busy, gnt_id, result}, 8'h00);
    check("rst_flags", {flags, alu_ctrl, 2'b00}, 8'h00);
    check("rst_ops", {alu_a, alu_b}, 8'h00);

    // add with overflow
    rst = 0; req0 = 1; a0 = 4'd3; b0 = 4'd5; op0 = 2'd0;
    step();
    check("add_busy", busy, 1'b1);
    req0 = 0;
    step();
    check("add_ack0", ack0, 1'b1);
    check("add_ack1", ack1, 1'b0);
    check("add_result", result, 8'd8);
    check("add_flags", flags, 8'b1010);
    step();

    // subtract to zero
    req1 = 1; a1 = 4'd5; b1 = 4'd5; op1 = 2'd1;
    step();
    req1 = 0;
    step();
    check("sub_ack1", ack1, 1'b1);
    check("sub_result", result, 8'd0);
    check("sub_flags", flags, 8'b0101);
    check("sub_gnt", gnt_id, 1'b1);
    step();

    // operand change after grant
    req0 = 1; a0 = 4'd3; b0 = 4'd5; op0 = 2'd0;
    step();
    req0 = 0; a0 = 4'd7;
    step();
    check("hold_result", result, 8'd8);
    step();

    // simultaneous requests after reset
    rst = 1; step();
    rst = 0;
    req0 = 1; a0 = 4'hC; b0 = 4'hA; op0 = 2'd2;
    req1 = 1; a1 = 4'h3; b1 = 4'h4; op1 = 2'd3;
    step(); step();
    check("sim_ack0", ack0, 1'b1);
    check("sim_res0", result, 8'h08);
    req0 = 0;
    step(); step(); step();
    check("sim_ack1", ack1, 1'b1);
    check("sim_res1", result, 8'h07);
    req1 = 0;
    step();

    // reset during EXEC
    req0 = 1; a0 = 4'd9; b0 = 4'd2; op0 = 2'd0;
    step();
    rst = 1; req0 = 0;
    step();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ack", {ack0, ack1}, 2'b00);
    check("mid_rst_out", {result, flags}, 8'h00);
    rst = 0;
    step(); step();
    req0 = 1; a0 = 4'd1; b0 = 4'd1; op0 = 2'd0;
    step();
    req0 = 0;
    step();
    check("post_rst_ack0", ack0, 1'b1);
    check("post_rst_res", result, 8'd2);
    step();

    // fairness under continuous contention
    rst = 1; step();
    rst = 0; req0 = 1; req1 = 1;
    a0 = 4'd1; b0 = 4'd2; op0 = 2'd0; a1 = 4'd6; b1 = 4'd3; op1 = 2'd1;
    busy_low = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (ack0) ack_seq.push_back(0);
      if (ack1) ack_seq.push_back(1);
      if (k < 12 && !busy) busy_low++;
    end
    req0 = 0; req1 = 0;
    check("fair_count", ack_seq.size(), 8'd4);
    check("fair_busy_low", busy_low, 8'd3);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("fair_seq", (i < ack_seq.size()) ? ack_seq[i] : 9, 8'd0);
`else
      check("fair_seq", (i < ack_seq.size()) ? ack_seq[i] : 9, i % 2);
`endif
    end
    step();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 39) == 0);
      req0 = ($urandom_range(0, 9) < 6);
      req1 = ($urandom_range(0, 9) < 6);
      a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
